maze_grid_mem: RTL and testbench
================================

MAZE_GRID_MEM -- requirements
Module: maze_grid_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the grid cell word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the cell address width; depth is 2^ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port address  input  ADDR_WIDTH  router cell address.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  router write data.
REQ-007 SHALL have port data_out  output  DATA_WIDTH  router read data, registered.
REQ-008 SHALL have port cs  input  1  router chip select.
REQ-009 SHALL have port we  input  1  router write enable; 1 = write, 0 = read.
REQ-010 SHALL have port D  input  1  router done flag.
REQ-011 SHALL have ports ld_valid in 1, ld_addr in ADDR_WIDTH, ld_data in DATA_WIDTH, ld_ready out 1: host preload channel.
REQ-012 SHALL have ports dump_valid out 1, dump_addr out ADDR_WIDTH, dump_data out DATA_WIDTH, dump_last out 1, dump_ready in 1: result dump channel.
REQ-013 SHALL have port mode  output  2  current state: 0 SERVE, 1 DUMP, 2 FINISHED.

Function
REQ-014 SHALL implement FSM SERVE -> DUMP -> FINISHED; SERVE is the reset state.
REQ-015 In SERVE, cs=1, we=1 SHALL write data_in to address at the clock edge; data_out unchanged.
REQ-016 In SERVE, cs=1, we=0 SHALL load data_out with mem[address] at the edge: one-cycle read latency.
REQ-017 With cs=0, data_out SHALL hold its last value.
REQ-018 Router read of an address written on the immediately preceding cycle SHALL return the new data.
REQ-019 In SERVE, ld_ready SHALL equal ~cs; a host write (ld_valid & ld_ready) SHALL write ld_data to ld_addr.
REQ-020 The router SHALL have priority: with cs=1 and ld_valid=1, the host write SHALL stall (ld_ready=0) and is not dropped.
REQ-021 SERVE -> DUMP SHALL occur on the edge where D=1 is sampled; a concurrent cs access in that cycle SHALL complete.
REQ-022 In DUMP and FINISHED, cs, we, and the load channel SHALL be ignored; ld_ready=0; data_out holds.
REQ-023 DUMP SHALL stream addresses 0 through 2^ADDR_WIDTH-1 in ascending order, dump_data = mem[dump_addr].
REQ-024 dump_valid SHALL rise no later than 2 cycles after DUMP entry.
REQ-025 While dump_valid=1 and dump_ready=0, dump_addr, dump_data, and dump_last SHALL stay stable.
REQ-026 A beat SHALL transfer on valid & ready; with dump_ready held 1, the stream SHALL sustain one beat per cycle.
REQ-027 dump_last SHALL be 1 only with the top-address beat; its transfer SHALL move to FINISHED with dump_valid=0 on the next cycle.
REQ-028 FINISHED SHALL be held until reset; D deassertion SHALL have no effect in DUMP or FINISHED.

Reset
REQ-029 reset=0 at a clock edge SHALL force mode=SERVE, data_out=0, dump_valid=0, dump_addr=0, dump_last=0, and ld_ready=1 (with cs=0), from any state.
REQ-030 Memory contents SHALL NOT be cleared by reset; contents after power-up are undefined.
REQ-031 Reset mid-DUMP SHALL abort the stream; after release, a new D pulse SHALL restart the dump from address 0.

Configuration
REQ-032 Macro MAZE_MEM_STATS_EN SHALL add outputs rd_count and wr_count (16 bits each) counting accepted router reads and writes, respectively.
REQ-033 The counters SHALL saturate at 16'hFFFF and clear on reset.
REQ-034 Without MAZE_MEM_STATS_EN, the ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Host preload addr 8'h10=8'h5A, cs=0; router read of 8'h10 -> data_out=8'h5A one cycle after the read cycle.
REQ-036 Router write addr 8'h20=8'hC3, then read 8'h20 on the next cycle -> data_out=8'hC3.
REQ-037 cs=1 and ld_valid=1 in the same cycle -> ld_ready=0 that cycle; the host write completes on the first cs=0 cycle.
REQ-038 Pulse D with dump_ready=1 -> 256 beats with addresses 0..255, dump_last only at 255, then mode=2 and dump_valid=0.
REQ-039 During the dump, hold dump_ready=0 for 3 cycles at addr 8'h05 -> beat 8'h05 stays stable, and no beat is skipped or repeated.
REQ-040 Assert reset=0 at dump beat 8'h40, then re-pulse D -> stream restarts at 8'h00 and memory contents are intact.

Source files
------------

// File: rtl/maze_grid_mem.sv
// Maze grid cell memory: router port, host preload channel and a post-run dump stream.
// Optional MAZE_MEM_STATS_EN adds saturating router read/write counters (rd_count, wr_count).
module maze_grid_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  D,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_last,
    input  logic                  dump_ready,
    output logic [1:0]            mode
`ifdef MAZE_MEM_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

    typedef enum logic [1:0] {
        ST_SERVE    = 2'd0,
        ST_DUMP     = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_dump_valid;
    logic [ADDR_WIDTH-1:0]   r_dump_addr;
    logic [DATA_WIDTH-1:0]   r_dump_data;
    logic                    r_dump_last;

    logic                    w_ld_ready;
    logic                    w_rtr_wr;
    logic                    w_rtr_rd;
    logic                    w_host_wr;
    logic                    w_dump_load;
    logic                    w_dump_adv;
    logic                    w_dump_done;
    logic [ADDR_WIDTH-1:0]   w_dump_addr_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_SERVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; D is only looked at while serving
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SERVE:    if (D) w_state_nxt = ST_DUMP;
            ST_DUMP:     if (r_dump_valid && dump_ready && r_dump_last) w_state_nxt = ST_FINISHED;
            ST_FINISHED: w_state_nxt = ST_FINISHED;
            default:     w_state_nxt = ST_SERVE;
        endcase
    end

    // Per-state strobes; router wins over host, so the host only sees ready when cs is low
    always_comb begin
        w_ld_ready      = 1'b0;
        w_rtr_wr        = 1'b0;
        w_rtr_rd        = 1'b0;
        w_host_wr       = 1'b0;
        w_dump_load     = 1'b0;
        w_dump_adv      = 1'b0;
        w_dump_done     = 1'b0;
        case (r_state)
            ST_SERVE: begin
                w_ld_ready = ~cs;
                w_rtr_wr   = cs & we;
                w_rtr_rd   = cs & ~we;
                w_host_wr  = ld_valid & ~cs;
            end
            ST_DUMP: begin
                w_dump_load = ~r_dump_valid;
                w_dump_adv  = r_dump_valid & dump_ready & ~r_dump_last;
                w_dump_done = r_dump_valid & dump_ready & r_dump_last;
            end
            default: begin
                w_ld_ready = 1'b0;
            end
        endcase
        w_dump_addr_nxt = w_dump_load ? '0 : r_dump_addr + 1'b1;
    end

    // Storage array; deliberately not reset
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_rtr_wr) begin
                r_mem[address] <= data_in;
            end else if (w_host_wr) begin
                r_mem[ld_addr] <= ld_data;
            end
        end
    end

    // Router read register and dump beat register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
        end else begin
            if (w_rtr_rd) begin
                r_data_out <= r_mem[address];
            end
            if (w_dump_load || w_dump_adv) begin
                r_dump_valid <= 1'b1;
                r_dump_addr  <= w_dump_addr_nxt;
                r_dump_data  <= r_mem[w_dump_addr_nxt];
                r_dump_last  <= (w_dump_addr_nxt == TOP_ADDR);
            end else if (w_dump_done) begin
                r_dump_valid <= 1'b0;
                r_dump_last  <= 1'b0;
            end
        end
    end

`ifdef MAZE_MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Saturating access counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rtr_rd && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
            if (w_rtr_wr && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign data_out   = r_data_out;
    assign ld_ready   = w_ld_ready;
    assign dump_valid = r_dump_valid;
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_dump_data;
    assign dump_last  = r_dump_last;
    assign mode       = r_state;

endmodule

// File: tb/tb_maze_grid_mem.sv
// Self-checking bench for maze_grid_mem: router/host access, priority, dump stream, stall and abort.
module tb_maze_grid_mem;

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       cs;
    logic       we;
    logic       D;
    logic       ld_valid;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       dump_valid;
    logic [7:0] dump_addr;
    logic [7:0] dump_data;
    logic       dump_last;
    logic       dump_ready;
    logic [1:0] mode;
`ifdef MAZE_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic [7:0] model [256];
    logic [7:0] rd_q [$];
    beat_t      exp_q [$];
    logic [7:0] last_dout;
    int         checks;
    int         errors;
    int         rd_exp;
    int         wr_exp;

    maze_grid_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in), .data_out(data_out),
        .cs(cs), .we(we), .D(D), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last), .dump_ready(dump_ready), .mode(mode)
`ifdef MAZE_MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One SERVE cycle: drive, check ld_ready, advance, check data_out against the scoreboard
    task automatic step(input logic s_cs, input logic s_we, input logic [7:0] s_addr,
                        input logic [7:0] s_din, input logic s_ldv,
                        input logic [7:0] s_ldaddr, input logic [7:0] s_lddata);
        logic rd;
        cs = s_cs; we = s_we; address = s_addr; data_in = s_din;
        ld_valid = s_ldv; ld_addr = s_ldaddr; ld_data = s_lddata;
        #1;
        checks++;
        if (ld_ready !== ~s_cs) begin
            errors++;
            $display("FAIL ld_ready got=%b exp=%b", ld_ready, ~s_cs);
        end
        rd = s_cs & ~s_we;
        if (rd) begin
            rd_q.push_back(model[s_addr]);
            rd_exp++;
        end
        if (s_cs && s_we) begin
            model[s_addr] = s_din;
            wr_exp++;
        end else if (s_ldv && !s_cs) begin
            model[s_ldaddr] = s_lddata;
        end
        @(posedge clk); #1;
        if (rd) last_dout = rd_q.pop_front();
        checks++;
        if (data_out !== last_dout) begin
            errors++;
            $display("FAIL data_out addr=%h got=%h exp=%h", s_addr, data_out, last_dout);
        end
`ifdef MAZE_MEM_STATS_EN
        checks++;
        if (rd_count !== 16'(rd_exp) || wr_count !== 16'(wr_exp)) begin
            errors++;
            $display("FAIL stats rd=%0d/%0d wr=%0d/%0d", rd_count, rd_exp, wr_count, wr_exp);
        end
`endif
        cs = 1'b0; we = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (mode !== 2'd0 || data_out !== 8'h00 || dump_valid !== 1'b0 || dump_addr !== 8'h00 ||
            dump_last !== 1'b0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s mode=%0d dout=%h dv=%b da=%h dl=%b rdy=%b exp 0/00/0/00/0/1",
                     tag, mode, data_out, dump_valid, dump_addr, dump_last, ld_ready);
        end
        last_dout = 8'h00; rd_exp = 0; wr_exp = 0;
    endtask

    task automatic test_reset();
        cs = 0; we = 0; D = 0; ld_valid = 0; dump_ready = 0;
        address = 0; data_in = 0; ld_addr = 0; ld_data = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;
    endtask

    task automatic fill_memory();
        for (int i = 0; i < 256; i++) step(0, 0, 8'h00, 8'h00, 1, 8'(i), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_preload_read();
        step(0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h5A);
        step(1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
        step(0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back();
        step(1, 1, 8'h20, 8'hC3, 0, 8'h00, 8'h00);
        step(1, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
        step(1, 1, 8'h21, 8'h3C, 0, 8'h00, 8'h00);
        step(1, 0, 8'h21, 8'h00, 0, 8'h00, 8'h00);
        step(1, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 8'h22, 8'h96);
        step(1, 0, 8'h22, 8'h00, 0, 8'h00, 8'h00);
    endtask

    task automatic test_priority();
        step(1, 0, 8'h30, 8'h00, 1, 8'h30, 8'hA7);
        step(0, 0, 8'h00, 8'h00, 1, 8'h30, 8'hA7);
        step(1, 0, 8'h30, 8'h00, 0, 8'h00, 8'h00);
    endtask

    // Pulse D and consume the stream; optional stall at one address or reset abort at another
    task automatic run_dump(input int stall_addr, input int abort_addr);
        int    first_valid;
        int    stalls;
        bit    done;
        bit    aborted;
        beat_t got;
        beat_t held;
        beat_t exp_b;
        cs = 1; we = 1; address = 8'h33; data_in = 8'hEE; D = 1; dump_ready = 0;
        model[8'h33] = 8'hEE;
        wr_exp++;
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back('{a: 8'(i), d: model[i], l: (i == 255)});
        @(posedge clk); #1;
        D = 0; cs = 0; we = 0; ld_valid = 1; ld_addr = 8'h81; ld_data = ~model[8'h81];
        #1;
        checks++;
        if (mode !== 2'd1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL dump_entry mode=%0d rdy=%b exp 1/0", mode, ld_ready);
        end
        cs = 1; we = 1; address = 8'h80; data_in = ~model[8'h80];
        first_valid = -1; stalls = 0; done = 0; held = '0; aborted = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (dump_valid && first_valid < 0) first_valid = cyc;
            got = '{a: dump_addr, d: dump_data, l: dump_last};
            if (abort_addr >= 0 && dump_valid && dump_addr == 8'(abort_addr)) begin
                cs = 0; we = 0; ld_valid = 0; dump_ready = 0; reset = 0;
                @(posedge clk); #1;
                check_reset_state("abort");
                reset = 1;
                done = 1; aborted = 1;
            end else begin
                dump_ready = !(stall_addr >= 0 && dump_valid && dump_addr == 8'(stall_addr) && stalls < 3);
                if (dump_valid && !dump_ready) begin
                    if (stalls == 0) held = got;
                    else begin
                        checks++;
                        if (got !== held) begin
                            errors++;
                            $display("FAIL stall_stable got=%h exp=%h", got, held);
                        end
                    end
                    stalls++;
                end
                if (dump_valid && dump_ready) begin
                    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL beat got a=%h d=%h l=%b exp a=%h d=%h l=%b",
                                 got.a, got.d, got.l, exp_b.a, exp_b.d, exp_b.l);
                    end
                    if (got.l) done = 1;
                end
                @(posedge clk); #1;
            end
        end
        cs = 0; we = 0; ld_valid = 0; dump_ready = 0;
        checks++;
        if (!done || first_valid < 0 || first_valid > 2) begin
            errors++;
            $display("FAIL dump_progress done=%b first_valid=%0d exp done=1 first_valid<=2", done, first_valid);
        end
        if (stall_addr >= 0) begin
            checks++;
            if (stalls != 3) begin
                errors++;
                $display("FAIL stall_count got=%0d exp=3", stalls);
            end
        end
        if (!aborted) begin
            checks++;
            if (mode !== 2'd2 || dump_valid !== 1'b0 || exp_q.size() != 0 || data_out !== last_dout) begin
                errors++;
                $display("FAIL dump_end mode=%0d dv=%b left=%0d dout=%h exp 2/0/0/%h",
                         mode, dump_valid, exp_q.size(), data_out, last_dout);
            end
        end
    endtask

    task automatic test_finished_hold();
        for (int i = 0; i < 3; i++) begin
            D = i[0]; cs = 1; we = 0; address = 8'h10; ld_valid = 1;
            @(posedge clk); #1;
            cs = 0;
            #1;
            checks++;
            if (mode !== 2'd2 || dump_valid !== 1'b0 || data_out !== last_dout || ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL finished_hold mode=%0d dv=%b dout=%h rdy=%b exp 2/0/%h/0",
                         mode, dump_valid, data_out, ld_ready, last_dout);
            end
        end
        D = 0; ld_valid = 0;
    endtask

    initial begin
        checks = 0; errors = 0; rd_exp = 0; wr_exp = 0; last_dout = 8'h00;
        test_reset();
        fill_memory();
        test_preload_read();
        test_back_to_back();
        test_priority();
        run_dump(-1, -1);
        test_finished_hold();
        test_reset();
        run_dump(5, -1);
        test_reset();
        run_dump(-1, 8'h40);
        run_dump(-1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
